echo_detector: RTL and testbench
================================

# echo_detector

Threshold-based echo qualifier that sits directly upstream of the recording channel in the rangefinder ADC domain. It watches the raw ADC stream after each transmit start and ignores the ringing/blanking window. It then qualifies a return as a run of consecutive samples above a programmable threshold with hysteresis. On qualification it emits the single-cycle `stop_pulse` consumed by the recording channel. If nothing qualifies within the range limit, it emits `stop_recording` instead. It also reports the echo's onset timestamp and peak amplitude.

## Interface
- `DATA_W`, default 8: ADC sample width.
- `CNT_W`, default 13: width of `abs_counter`, `blank_len`, `max_range`, timestamp.

- `clk`  in  1: fast ADC-domain clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `adc_data`  in  DATA_W: ADC sample, one per clk.
- `start_pulse`  in  1: transmit start, 1-cycle pulse (same pulse feeds the recording channel).
- `abs_counter`  in  CNT_W: free-running timestamp counter.
- `threshold`  in  DATA_W: upper (arming) threshold, unsigned.
- `hysteresis`  in  DATA_W: low threshold = `threshold - hysteresis`, saturating at 0.
- `blank_len`  in  CNT_W: cycles ignored after start.
- `min_width`  in  4: consecutive qualifying samples required; 0 treated as 1.
- `max_range`  in  CNT_W: timeout in cycles from start; 0 = no timeout.
- `stop_pulse`  out  1: 1-cycle echo-qualified pulse.
- `stop_recording`  out  1: 1-cycle timeout pulse.
- `echo_detected`  out  1: level; set on qualification, cleared on next start.
- `echo_timestamp`  out  CNT_W: `abs_counter` at the first sample of the qualified run.
- `echo_peak`  out  DATA_W: max sample over the echo, final when state returns to IDLE.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- Inputs `threshold`, `hysteresis`, `blank_len`, `min_width`, `max_range` are latched at start; changes mid-shot are ignored.
- The FSM has five states: IDLE, BLANK, ARMED, QUAL, DONE.
- IDLE: wait for `start_pulse`.
  - On start: clear `echo_detected`, `echo_peak`, `echo_timestamp`; clear `rel_cnt`.
  - Go to BLANK with `blank_cnt = blank_len`, or straight to ARMED if `blank_len == 0`.
- BLANK: decrement `blank_cnt` each cycle and go to ARMED on the edge where it reaches 0. Samples are ignored.
- ARMED: sample `>= threshold` → go to QUAL with `width_cnt = 1`, capture the candidate timestamp from `abs_counter`, and set peak = sample.
  - If `min_width` ≤ 1, qualify immediately at that edge.
- QUAL: sample `>=` low threshold → increment `width_cnt` and update peak = max(peak, sample).
  - When `width_cnt` reaches `min_width`: assert `stop_pulse`, set `echo_detected`, load `echo_timestamp` = candidate, go to DONE.
  - Sample below the low threshold → back to ARMED; candidate and peak are discarded.
- DONE: keep updating the peak while the sample is `>=` the low threshold. The first sample below it → IDLE.
- `rel_cnt` (CNT_W) increments every cycle while not IDLE and saturates at all-ones.
  - In BLANK/ARMED/QUAL, `rel_cnt == max_range` (max_range ≠ 0) → pulse `stop_recording`, go to IDLE, `echo_detected` stays 0.
  - In DONE, the same condition → IDLE with no pulse.
- Priorities:
  - Qualification beats timeout on the same edge.
  - `start_pulse` in any non-IDLE state restarts the shot exactly as from IDLE; no `stop_*` pulse is generated for the aborted shot.
- At most one of `stop_pulse` / `stop_recording` is emitted per shot.

## Timing
- All outputs are registered.
- Reset values: `stop_pulse` 0, `stop_recording` 0, `echo_detected` 0, `echo_timestamp` 0, `echo_peak` 0, `busy` 0; state IDLE.
  - Reset mid-shot aborts with no pulse.
- Start sampled at edge E0:
  - `busy` goes high after E0.
  - First compared sample is at edge E0+blank_len+1.
- Qualification:
  - First qualifying sample at edge Q sets the candidate timestamp to `abs_counter` at Q.
  - `stop_pulse` is high in the cycle following edge Q+min_width−1, i.e. one cycle of latency after the last required sample.
  - `echo_detected` and `echo_timestamp` update in that same cycle.
- Timeout: `stop_recording` is high in the cycle after the edge where `rel_cnt == max_range`. Since `rel_cnt` is 0 at E0+1, this is the edge E0+max_range+1.
- `stop_pulse` and `stop_recording` are high for exactly 1 cycle.

## Test plan
- Clean echo:
  - Setup: threshold=100, hyst=10, blank_len=20, min_width=3, max_range=0.
  - Stimulus: start at abs_counter=200, ADC low except samples 150,160,155,120,50 starting at abs_counter=300.
  - Expected: one `stop_pulse` after the 3rd sample, `echo_timestamp`=300, `echo_peak`=160, `echo_detected`=1.
- Blanking:
  - Setup: same as clean echo, with a 255 sample inside the first 20 cycles after start and no later echo.
  - Expected: no `stop_pulse`.
- Short glitch:
  - Stimulus: samples 120,120 then 80 (below the low threshold of 90).
  - Expected: back to ARMED, no pulse. A later 3-sample echo qualifies with its own timestamp.
- Hysteresis:
  - Stimulus: samples 105,95,95 with threshold=100, hyst=10.
  - Expected: qualifies (95 ≥ 90). With hyst=0 it does not.
- Timeout:
  - Setup: max_range=400, no echo.
  - Expected: `stop_recording` 1 cycle at E0+401, `echo_detected`=0, `busy` drops.
  - Corner case: an echo qualifying on that same edge gives `stop_pulse` only.
- Restart/reset:
  - `start_pulse` while in QUAL → no pulse, shot restarts, outputs cleared.
  - Synchronous reset mid-BLANK → all outputs 0 the next cycle.

Source files
------------

// File: rtl/echo_detector.sv
// Threshold/hysteresis echo qualifier for the rangefinder ADC stream.
// Emits stop_pulse on a qualified echo or stop_recording on range timeout.
module echo_detector #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              start_pulse,
  input  logic [CNT_W-1:0]  abs_counter,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] hysteresis,
  input  logic [CNT_W-1:0]  blank_len,
  input  logic [3:0]        min_width,
  input  logic [CNT_W-1:0]  max_range,
  output logic              stop_pulse,
  output logic              stop_recording,
  output logic              echo_detected,
  output logic [CNT_W-1:0]  echo_timestamp,
  output logic [DATA_W-1:0] echo_peak,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLANK,
    S_ARMED,
    S_QUAL,
    S_DONE
  } state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    blank_cnt_q, blank_cnt_n;
  logic [CNT_W-1:0]    rel_cnt_q, rel_cnt_n;
  logic [3:0]          width_cnt_q, width_cnt_n;
  logic [CNT_W-1:0]    cand_ts_q, cand_ts_n;
  logic [DATA_W-1:0]   thr_q, thr_n;
  logic [DATA_W-1:0]   low_q, low_n;
  logic [3:0]          min_w_q, min_w_n;
  logic [CNT_W-1:0]    max_range_q, max_range_n;
  logic                stop_pulse_n, stop_recording_n, echo_detected_n, busy_n;
  logic [CNT_W-1:0]    echo_timestamp_n;
  logic [DATA_W-1:0]   echo_peak_n;

  logic                timeout, above_thr, above_low;
  logic [DATA_W-1:0]   peak_max;

  assign timeout   = (max_range_q != '0) && (rel_cnt_q == max_range_q);
  assign above_thr = adc_data >= thr_q;
  assign above_low = adc_data >= low_q;
  assign peak_max  = (adc_data > echo_peak) ? adc_data : echo_peak;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_n          = state_q;
    blank_cnt_n      = blank_cnt_q;
    rel_cnt_n        = rel_cnt_q;
    width_cnt_n      = width_cnt_q;
    cand_ts_n        = cand_ts_q;
    thr_n            = thr_q;
    low_n            = low_q;
    min_w_n          = min_w_q;
    max_range_n      = max_range_q;
    stop_pulse_n     = 1'b0;
    stop_recording_n = 1'b0;
    echo_detected_n  = echo_detected;
    echo_timestamp_n = echo_timestamp;
    echo_peak_n      = echo_peak;

    if (state_q != S_IDLE && rel_cnt_q != '1)
      rel_cnt_n = rel_cnt_q + CNT_W'(1);

    if (start_pulse) begin
      // A start restarts the shot from any state; the aborted shot gets no pulse.
      thr_n            = threshold;
      low_n            = (hysteresis > threshold) ? '0 : threshold - hysteresis;
      min_w_n          = (min_width == 4'd0) ? 4'd1 : min_width;
      max_range_n      = max_range;
      echo_detected_n  = 1'b0;
      echo_timestamp_n = '0;
      echo_peak_n      = '0;
      rel_cnt_n        = '0;
      width_cnt_n      = '0;
      blank_cnt_n      = blank_len;
      state_n          = (blank_len == '0) ? S_ARMED : S_BLANK;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_BLANK: begin
          blank_cnt_n = blank_cnt_q - CNT_W'(1);
          if (timeout) begin
            stop_recording_n = 1'b1;
            state_n          = S_IDLE;
          end else if (blank_cnt_q == CNT_W'(1)) begin
            state_n = S_ARMED;
          end
        end
        S_ARMED: begin
          if (above_thr && min_w_q == 4'd1) begin
            stop_pulse_n     = 1'b1;
            echo_detected_n  = 1'b1;
            echo_timestamp_n = abs_counter;
            echo_peak_n      = adc_data;
            state_n          = S_DONE;
          end else if (timeout) begin
            stop_recording_n = 1'b1;
            state_n          = S_IDLE;
          end else if (above_thr) begin
            width_cnt_n = 4'd1;
            cand_ts_n   = abs_counter;
            echo_peak_n = adc_data;
            state_n     = S_QUAL;
          end
        end
        S_QUAL: begin
          // Qualification is checked before timeout so it wins a tie.
          if (above_low && (width_cnt_q + 4'd1) == min_w_q) begin
            stop_pulse_n     = 1'b1;
            echo_detected_n  = 1'b1;
            echo_timestamp_n = cand_ts_q;
            echo_peak_n      = peak_max;
            state_n          = S_DONE;
          end else if (timeout) begin
            stop_recording_n = 1'b1;
            echo_peak_n      = '0;
            state_n          = S_IDLE;
          end else if (above_low) begin
            width_cnt_n = width_cnt_q + 4'd1;
            echo_peak_n = peak_max;
          end else begin
            echo_peak_n = '0;
            state_n     = S_ARMED;
          end
        end
        S_DONE: begin
          if (above_low) echo_peak_n = peak_max;
          if (!above_low || timeout) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end

    busy_n = (state_n != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      blank_cnt_q    <= '0;
      rel_cnt_q      <= '0;
      width_cnt_q    <= '0;
      cand_ts_q      <= '0;
      thr_q          <= '0;
      low_q          <= '0;
      min_w_q        <= 4'd1;
      max_range_q    <= '0;
      stop_pulse     <= 1'b0;
      stop_recording <= 1'b0;
      echo_detected  <= 1'b0;
      echo_timestamp <= '0;
      echo_peak      <= '0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_n;
      blank_cnt_q    <= blank_cnt_n;
      rel_cnt_q      <= rel_cnt_n;
      width_cnt_q    <= width_cnt_n;
      cand_ts_q      <= cand_ts_n;
      thr_q          <= thr_n;
      low_q          <= low_n;
      min_w_q        <= min_w_n;
      max_range_q    <= max_range_n;
      stop_pulse     <= stop_pulse_n;
      stop_recording <= stop_recording_n;
      echo_detected  <= echo_detected_n;
      echo_timestamp <= echo_timestamp_n;
      echo_peak      <= echo_peak_n;
      busy           <= busy_n;
    end
  end

endmodule

// File: tb/tb_echo_detector.sv
// Directed bench for echo_detector: expected stop events are queued as stimulus
// is driven and matched against the pulses the DUT produces.
module tb_echo_detector;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 13;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] adc_data = '0;
  logic              start_pulse = 1'b0;
  logic [CNT_W-1:0]  abs_counter = '0;
  logic [DATA_W-1:0] threshold = '0;
  logic [DATA_W-1:0] hysteresis = '0;
  logic [CNT_W-1:0]  blank_len = '0;
  logic [3:0]        min_width = '0;
  logic [CNT_W-1:0]  max_range = '0;
  logic              stop_pulse, stop_recording, echo_detected, busy;
  logic [CNT_W-1:0]  echo_timestamp;
  logic [DATA_W-1:0] echo_peak;

  echo_detector #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .adc_data(adc_data), .start_pulse(start_pulse),
    .abs_counter(abs_counter), .threshold(threshold), .hysteresis(hysteresis),
    .blank_len(blank_len), .min_width(min_width), .max_range(max_range),
    .stop_pulse(stop_pulse), .stop_recording(stop_recording),
    .echo_detected(echo_detected), .echo_timestamp(echo_timestamp),
    .echo_peak(echo_peak), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit timeout;
    int at;
    int ts;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   t = 0;
  int   e0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_stop(input bit timeout, input int at, input int ts);
    exp_t e;
    e.timeout = timeout;
    e.at      = at;
    e.ts      = ts;
    exp_q.push_back(e);
  endtask

  // One clock: present sample/start with abs_counter = t, then match any stop pulse.
  task automatic tick(input logic [DATA_W-1:0] sample, input logic st);
    int   edge_abs;
    exp_t e;
    adc_data    = sample;
    start_pulse = st;
    abs_counter = CNT_W'(t);
    @(posedge clk);
    #1;
    edge_abs    = t;
    t++;
    start_pulse = 1'b0;
    if (stop_pulse || stop_recording) begin
      if (exp_q.size() == 0) begin
        check("stop_unexpected", 32'({stop_pulse, stop_recording}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("stop_kind", 32'({stop_pulse, stop_recording}), e.timeout ? 32'd1 : 32'd2);
        check("stop_edge", 32'(edge_abs), 32'(e.at));
        if (e.timeout) begin
          check("timeout_detected", 32'(echo_detected), 32'd0);
        end else begin
          check("stop_detected", 32'(echo_detected), 32'd1);
          check("stop_timestamp", 32'(echo_timestamp), 32'(e.ts));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick('0, 1'b0);
  endtask

  task automatic idle_until(input int target);
    while (t < target) tick('0, 1'b0);
  endtask

  task automatic start_shot(input int thr, input int hyst, input int blank, input int minw,
                            input int maxr, input logic [DATA_W-1:0] sample);
    threshold  = DATA_W'(thr);
    hysteresis = DATA_W'(hyst);
    blank_len  = CNT_W'(blank);
    min_width  = 4'(minw);
    max_range  = CNT_W'(maxr);
    e0 = t;
    tick(sample, 1'b1);
  endtask

  task automatic check_no_missing(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    idle(3);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_outputs", 32'({stop_pulse, stop_recording, echo_detected, echo_timestamp, echo_peak}), 32'd0);
    reset = 1'b0;
    idle(2);

    // Clean echo; threshold changed mid-shot must be ignored
    idle_until(200);
    start_shot(100, 10, 20, 3, 0, 8'd0);
    check("clean_busy", 32'(busy), 32'd1);
    threshold = 8'd250;
    idle_until(300);
    tick(8'd150, 1'b0);
    tick(8'd160, 1'b0);
    expect_stop(1'b0, 302, 300);
    tick(8'd155, 1'b0);
    tick(8'd120, 1'b0);
    tick(8'd50, 1'b0);
    idle(3);
    check_no_missing("clean_missing");
    check("clean_peak", 32'(echo_peak), 32'd160);
    check("clean_detected", 32'(echo_detected), 32'd1);
    check("clean_timestamp", 32'(echo_timestamp), 32'd300);
    check("clean_idle", 32'(busy), 32'd0);

    // Blanking: a large sample inside the blank window is ignored
    start_shot(100, 10, 20, 3, 0, 8'd0);
    idle(5);
    tick(8'd255, 1'b0);
    tick(8'd255, 1'b0);
    tick(8'd255, 1'b0);
    idle(80);
    check_no_missing("blank_missing");
    check("blank_detected", 32'(echo_detected), 32'd0);
    check("blank_busy", 32'(busy), 32'd1);

    // Short glitch, then a real echo with its own timestamp
    start_shot(100, 10, 20, 3, 0, 8'd0);
    idle(25);
    tick(8'd120, 1'b0);
    tick(8'd120, 1'b0);
    tick(8'd80, 1'b0);
    idle(4);
    check("glitch_detected", 32'(echo_detected), 32'd0);
    check("glitch_peak", 32'(echo_peak), 32'd0);
    begin
      int q;
      q = t;
      tick(8'd130, 1'b0);
      tick(8'd140, 1'b0);
      expect_stop(1'b0, q + 2, q);
      tick(8'd135, 1'b0);
    end
    tick(8'd10, 1'b0);
    idle(2);
    check_no_missing("glitch_missing");
    check("glitch_echo_peak", 32'(echo_peak), 32'd140);

    // Hysteresis: 105,95,95 qualifies with hyst=10 but not with hyst=0
    start_shot(100, 10, 0, 3, 0, 8'd0);
    begin
      int q;
      q = t;
      tick(8'd105, 1'b0);
      tick(8'd95, 1'b0);
      expect_stop(1'b0, q + 2, q);
      tick(8'd95, 1'b0);
    end
    tick(8'd0, 1'b0);
    idle(2);
    check_no_missing("hyst10_missing");
    start_shot(100, 0, 0, 3, 0, 8'd0);
    tick(8'd105, 1'b0);
    tick(8'd95, 1'b0);
    tick(8'd95, 1'b0);
    idle(4);
    check_no_missing("hyst0_missing");
    check("hyst0_detected", 32'(echo_detected), 32'd0);

    // min_width=0 acts as 1 and blank_len=0 compares the very next sample
    start_shot(100, 10, 0, 0, 0, 8'd0);
    expect_stop(1'b0, t, t);
    tick(8'd200, 1'b0);
    tick(8'd0, 1'b0);
    idle(2);
    check_no_missing("minw0_missing");
    check("minw0_peak", 32'(echo_peak), 32'd200);

    // Timeout with no echo
    start_shot(100, 10, 20, 3, 400, 8'd0);
    expect_stop(1'b1, e0 + 401, 0);
    idle_until(e0 + 410);
    check_no_missing("timeout_missing");
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_detected_after", 32'(echo_detected), 32'd0);

    // Qualification on the timeout edge wins
    start_shot(100, 10, 20, 3, 400, 8'd0);
    idle_until(e0 + 399);
    tick(8'd150, 1'b0);
    tick(8'd150, 1'b0);
    expect_stop(1'b0, e0 + 401, e0 + 399);
    tick(8'd150, 1'b0);
    tick(8'd0, 1'b0);
    idle(20);
    check_no_missing("tie_missing");
    check("tie_detected", 32'(echo_detected), 32'd1);

    // Restart while in QUAL: no pulse, outputs cleared, shot continues
    start_shot(100, 10, 0, 3, 0, 8'd0);
    tick(8'd150, 1'b0);
    tick(8'd150, 1'b0);
    start_shot(100, 10, 0, 3, 0, 8'd150);
    idle(5);
    check_no_missing("restart_missing");
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_cleared", 32'({echo_detected, echo_timestamp, echo_peak}), 32'd0);

    // Synchronous reset mid-BLANK
    start_shot(100, 10, 20, 3, 30, 8'd0);
    idle(5);
    check("preclear_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(8'd0, 1'b0);
    check("rst_outputs", 32'({busy, stop_pulse, stop_recording, echo_detected, echo_timestamp, echo_peak}), 32'd0);
    reset = 1'b0;
    idle(40);
    check_no_missing("rst_no_pulse");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
